// File: rtl/watchdog_supervisor_pkg.sv
// Shared state encoding and sizing helpers for the watchdog supervisor.
package watchdog_supervisor_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_GRACE = 2'd1,
        ST_RUN   = 2'd2,
        ST_FATAL = 2'd3
    } state_t;

    localparam int unsigned MS_PER_S = 32'd1000;

    function automatic int unsigned ms_to_cycles(input int unsigned clk_hz, input int unsigned ms);
        return (clk_hz / MS_PER_S) * ms;
    endfunction

    // Bits needed to hold 0..max_val, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 32'd1);
        return (w == 32'd0) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/watchdog_supervisor_if.sv
// Control/status bundle between the watchdog supervisor and its environment.
interface watchdog_supervisor_if #(
    parameter int unsigned Channels = 4,
    parameter int unsigned RetryW   = 2
);
    logic [Channels-1:0] ipEnable;
    logic [Channels-1:0] ipKick;
    logic                ipClearFatal;
    logic                opSubReset;
    logic                opFatal;
    logic                opTimeoutStrobe;
    logic [Channels-1:0] opTimedOut;
    logic [RetryW-1:0]   opRetries;
    logic [1:0]          opState;

    modport master (
        output ipEnable, ipKick, ipClearFatal,
        input  opSubReset, opFatal, opTimeoutStrobe, opTimedOut, opRetries, opState
    );

    modport slave (
        input  ipEnable, ipKick, ipClearFatal,
        output opSubReset, opFatal, opTimeoutStrobe, opTimedOut, opRetries, opState
    );
endinterface

// File: rtl/watchdog_supervisor_channel.sv
// One watchdog channel: kick detection, down counter and expiry flag.
module watchdog_supervisor_channel
    import watchdog_supervisor_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 10,
    parameter int unsigned EdgeSensitive = 1
) (
    input  logic ipClk,
    input  logic Reset,
    input  logic run_i,
    input  logic freeze_i,
    input  logic evt_i,
    input  logic enable_i,
    input  logic kick_i,
    output logic expired_o
);
    localparam int unsigned    CNT_W       = cnt_width(TimeoutCycles);
    localparam logic [CNT_W-1:0] RELOAD      = CNT_W'(TimeoutCycles);
    localparam logic [CNT_W-1:0] KICK_RELOAD = CNT_W'(TimeoutCycles - 32'd1);
    localparam bit             EDGE_MODE   = (EdgeSensitive != 32'd0);

    logic [1:0]       hist_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             kick_det;

    assign kick_det  = EDGE_MODE ? (hist_q[0] & ~hist_q[1]) : hist_q[0];
    assign expired_o = enable_i && (cnt_q == {CNT_W{1'b0}});

    // Counter next value: a timeout event anywhere wins over a kick on this channel.
    always_comb begin
        cnt_d = cnt_q;
        if (freeze_i) begin
            cnt_d = cnt_q;
        end else if (!run_i || !enable_i || evt_i) begin
            cnt_d = RELOAD;
        end else if (kick_det) begin
            cnt_d = KICK_RELOAD;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Kick history and counter registers.
    always_ff @(posedge ipClk) begin
        if (Reset) begin
            hist_q <= 2'b00;
            cnt_q  <= RELOAD;
        end else begin
            hist_q <= {hist_q[0], kick_i};
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/watchdog_supervisor.sv
// Multi-channel watchdog: holds the subsystem in reset, grants grace, enforces
// per-channel timeouts with bounded retries before latching FATAL.
module watchdog_supervisor
    import watchdog_supervisor_pkg::*;
#(
    parameter int unsigned Clk_Frequency     = 50_000_000,
    parameter int unsigned Channels          = 4,
    parameter int unsigned Timeout_ms        = 100,
    parameter int unsigned Grace_ms          = 500,
    parameter int unsigned ResetPulse_Cycles = 16,
    parameter int unsigned Max_Retries       = 3,
    parameter int unsigned Heal_ms           = 1000,
    parameter int unsigned EdgeSensitive     = 1
) (
    input  logic                  ipClk,
    input  logic                  Reset,
    watchdog_supervisor_if.slave  bus
);
    localparam int unsigned TIMEOUT_CYC = ms_to_cycles(Clk_Frequency, Timeout_ms);
    localparam int unsigned GRACE_CYC   = ms_to_cycles(Clk_Frequency, Grace_ms);
    localparam int unsigned HEAL_CYC    = ms_to_cycles(Clk_Frequency, Heal_ms);
    localparam int unsigned PW          = cnt_width(ResetPulse_Cycles);
    localparam int unsigned GW          = cnt_width(GRACE_CYC);
    localparam int unsigned HW          = cnt_width(HEAL_CYC);
    localparam int unsigned RW          = cnt_width(Max_Retries);
    localparam logic [PW-1:0] P_LAST    = PW'(ResetPulse_Cycles - 32'd1);
    localparam logic [GW-1:0] G_LAST    = GW'(GRACE_CYC - 32'd1);
    localparam logic [HW-1:0] H_LAST    = HW'(HEAL_CYC - 32'd1);
    localparam logic [RW-1:0] MAX_RET   = RW'(Max_Retries);

    state_t              state_q, state_d;
    logic [PW-1:0]       pulse_q, pulse_d;
    logic [GW-1:0]       grace_q, grace_d;
    logic [HW-1:0]       heal_q, heal_d;
    logic [RW-1:0]       retries_q, retries_d;
    logic                sub_reset_q, sub_reset_d;
    logic                fatal_q, fatal_d;
    logic                strobe_q, strobe_d;
    logic [Channels-1:0] timed_out_q, timed_out_d;
    logic [Channels-1:0] expired;
    logic                evt;
    logic                run;
    logic                freeze;

    assign run    = (state_q == ST_RUN);
    assign freeze = (state_q == ST_FATAL);
    assign evt    = run && (|expired);

    for (genvar g = 0; g < Channels; g++) begin : g_ch
        watchdog_supervisor_channel #(
            .TimeoutCycles (TIMEOUT_CYC),
            .EdgeSensitive (EdgeSensitive)
        ) u_ch (
            .ipClk     (ipClk),
            .Reset     (Reset),
            .run_i     (run),
            .freeze_i  (freeze),
            .evt_i     (evt),
            .enable_i  (bus.ipEnable[g]),
            .kick_i    (bus.ipKick[g]),
            .expired_o (expired[g])
        );
    end

    // Supervisor FSM next state; a timeout event outranks healing in the same cycle.
    always_comb begin
        state_d     = state_q;
        retries_d   = retries_q;
        fatal_d     = fatal_q;
        strobe_d    = 1'b0;
        timed_out_d = timed_out_q;
        case (state_q)
            ST_HOLD: begin
                if (pulse_q == P_LAST) state_d = ST_GRACE;
                else                   state_d = ST_HOLD;
            end
            ST_GRACE: begin
                if (grace_q == G_LAST) state_d = ST_RUN;
                else                   state_d = ST_GRACE;
            end
            ST_RUN: begin
                if (evt) begin
                    strobe_d    = 1'b1;
                    timed_out_d = expired;
                    if (retries_q == MAX_RET) begin
                        state_d = ST_FATAL;
                        fatal_d = 1'b1;
                    end else begin
                        state_d   = ST_HOLD;
                        retries_d = retries_q + RW'(1);
                    end
                end else if (heal_q == H_LAST) begin
                    retries_d = {RW{1'b0}};
                end else begin
                    retries_d = retries_q;
                end
            end
            ST_FATAL: begin
                if (bus.ipClearFatal) begin
                    state_d   = ST_HOLD;
                    retries_d = {RW{1'b0}};
                    fatal_d   = 1'b0;
                end else begin
                    state_d = ST_FATAL;
                end
            end
            default: state_d = ST_HOLD;
        endcase
        sub_reset_d = (state_d == ST_HOLD) || (state_d == ST_FATAL);
        // Phase timers restart from zero whenever their state is (re)entered.
        pulse_d = ((state_q == ST_HOLD) && (state_d == ST_HOLD)) ? pulse_q + PW'(1) : {PW{1'b0}};
        grace_d = ((state_q == ST_GRACE) && (state_d == ST_GRACE)) ? grace_q + GW'(1) : {GW{1'b0}};
        heal_d  = ((state_q == ST_RUN) && (state_d == ST_RUN)) ?
                  ((heal_q == H_LAST) ? heal_q : heal_q + HW'(1)) : {HW{1'b0}};
    end

    // State and output registers.
    always_ff @(posedge ipClk) begin
        if (Reset) begin
            state_q     <= ST_HOLD;
            pulse_q     <= {PW{1'b0}};
            grace_q     <= {GW{1'b0}};
            heal_q      <= {HW{1'b0}};
            retries_q   <= {RW{1'b0}};
            sub_reset_q <= 1'b1;
            fatal_q     <= 1'b0;
            strobe_q    <= 1'b0;
            timed_out_q <= {Channels{1'b0}};
        end else begin
            state_q     <= state_d;
            pulse_q     <= pulse_d;
            grace_q     <= grace_d;
            heal_q      <= heal_d;
            retries_q   <= retries_d;
            sub_reset_q <= sub_reset_d;
            fatal_q     <= fatal_d;
            strobe_q    <= strobe_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign bus.opState         = state_q;
    assign bus.opSubReset      = sub_reset_q;
    assign bus.opFatal         = fatal_q;
    assign bus.opTimeoutStrobe = strobe_q;
    assign bus.opTimedOut      = timed_out_q;
    assign bus.opRetries       = retries_q;
endmodule

// File: tb/tb_watchdog_supervisor.sv
// Bench for watchdog_supervisor: deadline-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_watchdog_supervisor;
    localparam int T = 10;
    localparam int G = 20;
    localparam int P = 4;
    localparam int R = 2;
    localparam int H = 50;

    logic ipClk;
    logic Reset;

    watchdog_supervisor_if #(.Channels(4), .RetryW(2)) bus ();

    watchdog_supervisor #(
        .Clk_Frequency     (1000),
        .Channels          (4),
        .Timeout_ms        (10),
        .Grace_ms          (20),
        .ResetPulse_Cycles (4),
        .Max_Retries       (2),
        .Heal_ms           (50),
        .EdgeSensitive     (1)
    ) dut (
        .ipClk (ipClk),
        .Reset (Reset),
        .bus   (bus)
    );

    int       n_checks = 0;
    int       n_fail   = 0;
    bit       chk_on   = 1'b0;
    int       m_phase, m_t, m_ret;
    bit       m_fatal, m_strobe;
    logic [3:0] m_mask, k1, k2;
    longint   dl [4];
    longint   gcyc = 0;

    initial begin
        ipClk = 1'b0;
        forever #5 ipClk = ~ipClk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
        end
    endtask

    // Reference: phase + time-in-phase, channel expiry as an absolute deadline cycle.
    task automatic model_step();
        logic [3:0] kdet, hit;
        if (Reset) begin
            m_phase = 0; m_t = 0; m_ret = 0; m_fatal = 1'b0; m_strobe = 1'b0;
            m_mask = 4'h0; k1 = 4'h0; k2 = 4'h0;
        end else begin
            kdet = k1 & ~k2;
            m_strobe = 1'b0;
            if (m_phase == 0) begin
                m_t++;
                if (m_t == P) begin m_phase = 1; m_t = 0; end
            end else if (m_phase == 1) begin
                m_t++;
                if (m_t == G) begin
                    m_phase = 2; m_t = 0;
                    for (int i = 0; i < 4; i++) dl[i] = gcyc + 1 + T;
                end
            end else if (m_phase == 2) begin
                hit = 4'h0;
                for (int i = 0; i < 4; i++) if (bus.ipEnable[i] && dl[i] == gcyc) hit[i] = 1'b1;
                if (hit != 4'h0) begin
                    m_strobe = 1'b1; m_mask = hit; m_t = 0;
                    if (m_ret == R) begin m_phase = 3; m_fatal = 1'b1; end
                    else begin m_ret++; m_phase = 0; end
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        if (!bus.ipEnable[i]) dl[i] = gcyc + 1 + T;
                        else if (kdet[i])     dl[i] = gcyc + T;
                    end
                    m_t++;
                    if (m_t >= H) m_ret = 0;
                end
            end else begin
                if (bus.ipClearFatal) begin m_phase = 0; m_t = 0; m_ret = 0; m_fatal = 1'b0; end
            end
            k2 = k1;
            k1 = bus.ipKick;
        end
        gcyc++;
    endtask

    always @(negedge ipClk) begin
        if (chk_on) begin
            chk("state",     32'(bus.opState),         32'(m_phase));
            chk("sub_reset", 32'(bus.opSubReset),      32'((m_phase == 0) || (m_phase == 3)));
            chk("fatal",     32'(bus.opFatal),         32'(m_fatal));
            chk("strobe",    32'(bus.opTimeoutStrobe), 32'(m_strobe));
            chk("timed_out", 32'(bus.opTimedOut),      32'(m_mask));
            chk("retries",   32'(bus.opRetries),       32'(m_ret));
        end
    end

    task automatic tick();
        @(posedge ipClk);
        #1;
        model_step();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        chk_on = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    task automatic wait_strobe(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (bus.opTimeoutStrobe === 1'b1) begin n = i; break; end
        end
    endtask

    task automatic wait_state(input logic [1:0] st, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (bus.opState === st) begin n = i; break; end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: run exceeded time limit after %0d checks", n_checks);
        $fatal(1, "watchdog bench time limit reached");
    end

    initial begin
        int g, r, s, n, h, nstrobe;
        int dens [4];
        Reset = 1'b1;
        bus.ipEnable = 4'h0; bus.ipKick = 4'h0; bus.ipClearFatal = 1'b0;

        // Start-up with no kicks: pulse, grace, run, full expiry.
        bus.ipEnable = 4'hF;
        do_reset();
        chk("rst_state", 32'(bus.opState), 32'd0);
        chk("rst_subreset", 32'(bus.opSubReset), 32'd1);
        chk("rst_retries", 32'(bus.opRetries), 32'd0);
        chk("rst_timed_out", 32'(bus.opTimedOut), 32'd0);
        g = -1; r = -1; s = -1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (g < 0 && bus.opState === 2'd1) g = i;
            if (r < 0 && bus.opState === 2'd2) r = i;
            if (bus.opTimeoutStrobe === 1'b1) begin s = i; break; end
        end
        chk("grace_start_cycle", 32'(g), 32'd4);
        chk("run_start_cycle", 32'(r), 32'd24);
        chk("t1_strobe_cycle", 32'(s), 32'd35);
        chk("t1_timed_out", 32'(bus.opTimedOut), 32'hF);
        chk("t1_retries", 32'(bus.opRetries), 32'd1);
        tick();
        chk("t1_strobe_single", 32'(bus.opTimeoutStrobe), 32'd0);

        // Consecutive failures into FATAL, then clear.
        wait_strobe(100, n);
        chk("t4_second_timeout", 32'(n), 32'd34);
        chk("t4_retries2", 32'(bus.opRetries), 32'd2);
        wait_strobe(100, n);
        chk("t4_third_timeout", 32'(n), 32'd35);
        repeat (5) tick();
        chk("t4_fatal_state", 32'(bus.opState), 32'd3);
        chk("t4_fatal_flag", 32'(bus.opFatal), 32'd1);
        chk("t4_fatal_subreset", 32'(bus.opSubReset), 32'd1);
        bus.ipClearFatal = 1'b1;
        tick();
        bus.ipClearFatal = 1'b0;
        chk("t4_clear_state", 32'(bus.opState), 32'd0);
        chk("t4_clear_retries", 32'(bus.opRetries), 32'd0);
        chk("t4_clear_fatal", 32'(bus.opFatal), 32'd0);
        wait_strobe(100, n);
        chk("t4_resume_timeout", 32'(n), 32'd35);

        // Regular kicks on ch0 only: no timeout, retry count heals.
        bus.ipEnable = 4'b0001;
        h = -1; nstrobe = 0;
        for (int i = 1; i <= 200; i++) begin
            bus.ipKick[0] = (i % 8 == 0);
            tick();
            if (bus.opTimeoutStrobe === 1'b1) nstrobe++;
            if (h < 0 && bus.opRetries === 2'd0) h = i;
        end
        bus.ipKick = 4'h0;
        chk("t2_no_timeout", 32'(nstrobe), 32'd0);
        chk("t2_heal_cycle", 32'(h), 32'd74);

        // Kick held high: only its rising edge counts.
        do_reset();
        repeat (26) tick();
        bus.ipKick[0] = 1'b1;
        wait_strobe(40, n);
        chk("t3_held_kick_timeout", 32'(n), 32'd12);
        chk("t3_timed_out", 32'(bus.opTimedOut), 32'h1);
        bus.ipKick = 4'h0;

        // ch2 kicked on its expiry cycle; ch2+ch3 expire together.
        bus.ipEnable = 4'hF;
        do_reset();
        s = -1;
        for (int i = 1; i <= 60; i++) begin
            bus.ipKick[1:0] = (i % 2 == 1) ? 2'b11 : 2'b00;
            bus.ipKick[2]   = (i == 34);
            tick();
            if (bus.opTimeoutStrobe === 1'b1) begin s = i; break; end
        end
        chk("t5_strobe_cycle", 32'(s), 32'd35);
        chk("t5_timed_out", 32'(bus.opTimedOut), 32'hC);
        chk("t5_single_retry", 32'(bus.opRetries), 32'd1);
        bus.ipKick = 4'h0;

        // Reset mid-HOLD and mid-GRACE restarts a full pulse.
        do_reset();
        repeat (2) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("t6_hold_rst_state", 32'(bus.opState), 32'd0);
        wait_state(2'd1, 20, n);
        chk("t6_hold_rst_pulse", 32'(n), 32'd4);
        repeat (8) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("t6_grace_rst_state", 32'(bus.opState), 32'd0);
        chk("t6_grace_rst_subreset", 32'(bus.opSubReset), 32'd1);
        wait_state(2'd1, 20, n);
        chk("t6_grace_rst_pulse", 32'(n), 32'd4);

        // Randomized traffic against the model.
        bus.ipEnable = 4'hF;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (c % 300 == 0) begin
                for (int j = 0; j < 4; j++) dens[j] = int'($urandom_range(1, 14));
            end
            Reset = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 39) == 0) begin
                int j;
                j = int'($urandom_range(0, 3));
                bus.ipEnable[j] = ~bus.ipEnable[j];
            end
            for (int j = 0; j < 4; j++) bus.ipKick[j] = ($urandom_range(0, dens[j]) == 0);
            bus.ipClearFatal = ($urandom_range(0, 15) == 0);
            tick();
        end
        Reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
